// File: rtl/dist_ram_fifo_ctl_pkg.sv
// Shared defaults for the show-ahead FIFO controller and its bus interface.
package dist_ram_fifo_ctl_pkg;

  localparam int unsigned DEF_NUM_COL      = 16;
  localparam int unsigned DEF_COL_WIDTH    = 32;
  localparam int unsigned DEF_ADDR_WIDTH   = 5;
  localparam int unsigned DEF_AFULL_THRESH = 28;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/dist_ram_fifo_ctl_if.sv
// Push / pop / status bundle of the FIFO controller; slave is the FIFO side.
interface dist_ram_fifo_ctl_if
  import dist_ram_fifo_ctl_pkg::*;
#(
  parameter int W  = DEF_NUM_COL * DEF_COL_WIDTH,
  parameter int LW = DEF_ADDR_WIDTH + 1
);
  logic          flush;
  logic          push;
  logic [W-1:0]  push_data;
  logic          full;
  logic          almost_full;
  logic [LW-1:0] level;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          overflow_err;

  modport slave (
    input  flush, push, push_data, out_ready,
    output full, almost_full, level, out_valid, out_data, overflow_err
  );

  modport master (
    output flush, push, push_data, out_ready,
    input  full, almost_full, level, out_valid, out_data, overflow_err
  );
endinterface

// File: rtl/dist_ram_fifo_ctl_dist_ram_1w.sv
// Simple dual-port RAM: port A column-enabled write, both ports registered read.
module dist_ram_1w
  import dist_ram_fifo_ctl_pkg::*;
#(
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic [NUM_COL-1:0]            wen_a,
  input  logic [ADDR_WIDTH-1:0]         addr_a,
  input  logic [NUM_COL*COL_WIDTH-1:0]  din_a,
  output logic [NUM_COL*COL_WIDTH-1:0]  dout_a,
  input  logic [ADDR_WIDTH-1:0]         addr_b,
  output logic [NUM_COL*COL_WIDTH-1:0]  dout_b
);
  localparam int W     = NUM_COL * COL_WIDTH;
  localparam int DEPTH = int'(fifo_depth(ADDR_WIDTH));

  logic [W-1:0] mem_q [DEPTH];

  // Reads return the pre-write contents when the addresses collide.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (wen_a[c]) begin
        mem_q[addr_a][c*COL_WIDTH +: COL_WIDTH] <= din_a[c*COL_WIDTH +: COL_WIDTH];
      end
    end
    dout_a <= mem_q[addr_a];
    dout_b <= mem_q[addr_b];
  end

endmodule

// File: rtl/dist_ram_fifo_ctl.sv
// Show-ahead FIFO controller around dist_ram_1w: pointers, level, flags and
// a registered out_valid that hides the port-B read latency.
module dist_ram_fifo_ctl
  import dist_ram_fifo_ctl_pkg::*;
#(
  parameter int NUM_COL      = DEF_NUM_COL,
  parameter int COL_WIDTH    = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEF_AFULL_THRESH
) (
  input  logic               clock,
  input  logic               reset_n,
  dist_ram_fifo_ctl_if.slave bus
);
  localparam int W     = NUM_COL * COL_WIDTH;
  localparam int DEPTH = int'(fifo_depth(ADDR_WIDTH));
  localparam int PW    = ADDR_WIDTH + 1;

  localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;

  logic          push_ok;
  logic          pop;
  logic [PW-1:0] rd_ptr_next;
  logic [W-1:0]  ram_dout_b;

  always_comb begin
    push_ok     = bus.push & ~full_q & ~bus.flush;
    pop         = out_valid_q & bus.out_ready & ~bus.flush;
    rd_ptr_next = rd_ptr_q + PW'(pop);

    wr_ptr_d    = wr_ptr_q + PW'(push_ok);
    rd_ptr_d    = rd_ptr_next;
    level_d     = level_q + PW'(push_ok) - PW'(pop);
    // Compare against the pre-update write pointer so an entry is only shown
    // once its write edge has passed and the RAM read sees the new data.
    out_valid_d = ~bus.flush & (rd_ptr_next != wr_ptr_q);
    overflow_d  = overflow_q | (bus.push & full_q & ~bus.flush);

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    full_d        = (level_d == DEPTH_L);
    almost_full_d = (level_d >= AFULL_L);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  dist_ram_1w #(
    .NUM_COL    (NUM_COL),
    .COL_WIDTH  (COL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk    (clock),
    .wen_a  ({NUM_COL{push_ok}}),
    .addr_a (wr_ptr_q[ADDR_WIDTH-1:0]),
    .din_a  (bus.push_data),
    .dout_a (),
    .addr_b (rd_ptr_next[ADDR_WIDTH-1:0]),
    .dout_b (ram_dout_b)
  );

  assign bus.out_data     = ram_dout_b;
  assign bus.out_valid    = out_valid_q;
  assign bus.level        = level_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_dist_ram_fifo_ctl.sv
// Directed bench for dist_ram_fifo_ctl: queue-based reference model checked
// every cycle, plus hand-computed checkpoints for each scenario.
module tb_dist_ram_fifo_ctl;
  import dist_ram_fifo_ctl_pkg::*;

  localparam int NC    = DEF_NUM_COL;
  localparam int CW    = DEF_COL_WIDTH;
  localparam int AW    = DEF_ADDR_WIDTH;
  localparam int AF    = DEF_AFULL_THRESH;
  localparam int DEPTH = 32;
  localparam int W     = NC * CW;
  localparam int LW    = AW + 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dist_ram_fifo_ctl_if #(.W(W), .LW(LW)) bus ();

  dist_ram_fifo_ctl #(
    .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [31:0] v);
    return {NC{v}};
  endfunction

  task automatic drive(input bit p, input logic [W-1:0] d, input bit r, input bit f);
    bus.push      = p;
    bus.push_data = d;
    bus.out_ready = r;
    bus.flush     = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: ordered queue of accepted entries tagged with push cycle.
  typedef struct {
    logic [W-1:0] d;
    int           cyc;
  } ent_t;

  ent_t mq[$];
  int   ncyc    = 0;
  bit   m_valid = 1'b0;
  bit   m_ovf   = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      chk("rst_valid", W'(bus.out_valid), '0);
      chk("rst_level", W'(bus.level), '0);
      chk("rst_full", W'(bus.full), '0);
      chk("rst_afull", W'(bus.almost_full), '0);
      chk("rst_ovf", W'(bus.overflow_err), '0);
    end else begin
      bit   m_full;
      bit   pop;
      bit   push_ok;
      ent_t e;
      m_full = (mq.size() == DEPTH);
      chk("m_valid", W'(bus.out_valid), W'(m_valid));
      chk("m_level", W'(bus.level), W'(mq.size()));
      chk("m_full", W'(bus.full), W'(m_full));
      chk("m_afull", W'(bus.almost_full), W'(mq.size() >= AF));
      chk("m_ovf", W'(bus.overflow_err), W'(m_ovf));
      if (m_valid) chk("m_data", bus.out_data, mq[0].d);

      pop     = m_valid && bus.out_ready && !bus.flush;
      push_ok = bus.push && !m_full && !bus.flush;
      if (bus.push && m_full && !bus.flush) m_ovf = 1'b1;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push_ok) begin
          e.d   = bus.push_data;
          e.cyc = ncyc;
          mq.push_back(e);
        end
      end
      // Entry becomes visible two cycles after the cycle it was pushed in.
      m_valid = !bus.flush && (mq.size() > 0) && (mq[0].cyc <= ncyc - 1);
    end
    ncyc++;
  end

  task automatic drain(input string name);
    int budget;
    budget = 0;
    drive(1'b0, '0, 1'b1, 1'b0);
    while (bus.level != 0 && budget < 80) begin
      tick();
      budget++;
    end
    chk(name, W'(bus.level), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ovf_before;
    int   k;
    int   budget;

    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // 1: single push latency
    chk("t1_rst_valid", W'(bus.out_valid), '0);
    chk("t1_rst_level", W'(bus.level), '0);
    chk("t1_rst_ovf", W'(bus.overflow_err), '0);
    drive(1'b1, rep(32'hA5), 1'b1, 1'b0);
    chk("t1_c0_valid", W'(bus.out_valid), '0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t1_c1_valid", W'(bus.out_valid), '0);
    chk("t1_c1_level", W'(bus.level), W'(1));
    tick();
    chk("t1_c2_valid", W'(bus.out_valid), W'(1));
    chk("t1_c2_data", bus.out_data, rep(32'hA5));
    chk("t1_c2_level", W'(bus.level), W'(1));
    tick();
    chk("t1_c3_level", W'(bus.level), '0);
    chk("t1_c3_valid", W'(bus.out_valid), '0);

    // 4: flush beats simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rep(32'd100 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t4_fill_level", W'(bus.level), W'(10));
    chk("t4_fill_valid", W'(bus.out_valid), W'(1));
    ovf_before = bus.overflow_err;
    drive(1'b1, rep(32'hDEAD), 1'b1, 1'b1);
    tick();
    chk("t4_flush_level", W'(bus.level), '0);
    chk("t4_flush_valid", W'(bus.out_valid), '0);
    chk("t4_flush_full", W'(bus.full), '0);
    chk("t4_flush_ovf", W'(bus.overflow_err), W'(ovf_before));
    drive(1'b1, rep(32'h77), 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t4_p1_valid", W'(bus.out_valid), '0);
    tick();
    chk("t4_p2_valid", W'(bus.out_valid), W'(1));
    chk("t4_p2_data", bus.out_data, rep(32'h77));
    tick();
    chk("t4_p3_level", W'(bus.level), '0);

    // 2: fill to full, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_level", W'(bus.level), W'(i));
      chk("t2_afull", W'(bus.almost_full), W'(i >= AF));
      drive(1'b1, W'(i), 1'b0, 1'b0);
      tick();
    end
    chk("t2_full", W'(bus.full), W'(1));
    chk("t2_level32", W'(bus.level), W'(32));
    chk("t2_ovf_pre", W'(bus.overflow_err), '0);
    drive(1'b1, rep(32'hFFFF_FFFF), 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t2_ovf", W'(bus.overflow_err), W'(1));
    chk("t2_level_hold", W'(bus.level), W'(32));
    drive(1'b0, '0, 1'b1, 1'b0);
    k = 0;
    budget = 0;
    while (k < DEPTH && budget < 80) begin
      if (bus.out_valid) begin
        chk("t2_drain_data", bus.out_data, W'(k));
        k++;
      end
      tick();
      budget++;
    end
    chk("t2_drain_count", W'(k), W'(DEPTH));
    chk("t2_empty", W'(bus.level), '0);

    // 5: pop accepted, push rejected while full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rep(32'd200 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_full", W'(bus.full), W'(1));
    chk("t5_valid", W'(bus.out_valid), W'(1));
    drive(1'b1, rep(32'hBAD), 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_level", W'(bus.level), W'(31));
    chk("t5_notfull", W'(bus.full), '0);
    chk("t5_ovf", W'(bus.overflow_err), W'(1));
    drain("t5_drain");

    // 3: streaming push/pop across pointer wrap
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, rep(32'd1000 + c), 1'b1, 1'b0);
      if (c >= 2) begin
        chk("t3_nogap", W'(bus.out_valid), W'(1));
        chk("t3_data", bus.out_data, rep(32'd1000 + c - 2));
      end
      if (c >= 1) chk("t3_level", W'((bus.level == 1) || (bus.level == 2)), W'(1));
      tick();
    end
    drain("t3_drain");

    // 6: asynchronous reset mid-burst, then no stale data
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, rep(32'd300 + i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t6_level7", W'(bus.level), W'(7));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", W'(bus.out_valid), '0);
    chk("t6_async_level", W'(bus.level), '0);
    chk("t6_async_full", W'(bus.full), '0);
    chk("t6_async_afull", W'(bus.almost_full), '0);
    chk("t6_async_ovf", W'(bus.overflow_err), '0);
    tick();
    tick();
    reset_n = 1'b1;
    drive(1'b1, rep(32'h5), 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t6_p1_valid", W'(bus.out_valid), '0);
    tick();
    chk("t6_p2_valid", W'(bus.out_valid), W'(1));
    chk("t6_p2_data", bus.out_data, rep(32'h5));
    tick();
    chk("t6_p3_level", W'(bus.level), '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
